// File: rtl/seq_chain_ctrl.sv
// rtl/seq_chain_ctrl.sv - pattern-chain step scheduler for the bit-sequencer voice path
//
// Plays a bank of NPAT step patterns in slot order. Each slot replays its
// pattern rep times. Every step starts with a one-cycle step_trig that carries
// the step's gate bit. A repeat count of 0 marks the end of the chain.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (also clears the bank)
//   start, stop       control pulses; stop has priority
//   loop_mode         1 = wrap to slot 0 at chain end, 0 = stop at chain end
//   len               clocks per step, taken at every step boundary (0 acts as 1)
//   wr_en/wr_addr/wr_pat/wr_rep   bank write port
//   running           high while playing
//   step_trig, gate   step start pulse and its pattern bit
//   step_idx, pat_idx position currently playing
//   chain_done        one-cycle pulse when a non-looping chain ends
module seq_chain_ctrl #(
    parameter int DEPTH = 4,
    parameter int NPAT  = 4,
    parameter int LENW  = 24,
    localparam int AW   = (NPAT > 1) ? $clog2(NPAT) : 1,
    localparam int SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_mode,
    input  logic [LENW-1:0]  len,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DEPTH-1:0] wr_pat,
    input  logic [3:0]       wr_rep,
    output logic             running,
    output logic             step_trig,
    output logic             gate,
    output logic [SW-1:0]    step_idx,
    output logic [AW-1:0]    pat_idx,
    output logic             chain_done
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_RUN    = 1'b1;
    localparam logic [SW-1:0] LAST_STEP = SW'(DEPTH - 1);
    localparam logic [AW:0]   NPAT_W    = (AW + 1)'(NPAT);

    logic [0:0]       state_q, state_d;
    logic [LENW-1:0]  div_cnt_q, div_cnt_d;
    logic [LENW-1:0]  lim_q, lim_d;         // last divider count of the current step
    logic [SW-1:0]    step_idx_q, step_idx_d;
    logic [AW-1:0]    pat_idx_q, pat_idx_d;
    logic [3:0]       loop_cnt_q, loop_cnt_d;
    logic [DEPTH-1:0] act_pat_q, act_pat_d;
    logic [3:0]       act_rep_q, act_rep_d;
    logic             step_trig_q, step_trig_d;
    logic             gate_q, gate_d;
    logic             chain_done_q, chain_done_d;
    logic [DEPTH-1:0] bank_pat_q [NPAT];
    logic [DEPTH-1:0] bank_pat_d [NPAT];
    logic [3:0]       bank_rep_q [NPAT];
    logic [3:0]       bank_rep_d [NPAT];

    logic [LENW-1:0]  len_lim;
    logic [AW:0]      nxt;
    logic [AW-1:0]    enter_slot;
    logic             do_enter;
    logic             do_end;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        lim_d        = lim_q;
        step_idx_d   = step_idx_q;
        pat_idx_d    = pat_idx_q;
        loop_cnt_d   = loop_cnt_q;
        act_pat_d    = act_pat_q;
        act_rep_d    = act_rep_q;
        step_trig_d  = 1'b0;
        gate_d       = 1'b0;
        chain_done_d = 1'b0;
        bank_pat_d   = bank_pat_q;
        bank_rep_d   = bank_rep_q;
        do_enter     = 1'b0;
        do_end       = 1'b0;
        enter_slot   = '0;

        if (wr_en) begin
            bank_pat_d[wr_addr] = wr_pat;
            bank_rep_d[wr_addr] = wr_rep;
        end

        len_lim = (len == '0) ? '0 : len - LENW'(1);
        nxt     = {1'b0, pat_idx_q} + (AW + 1)'(1);

        if (stop) begin
            state_d    = ST_IDLE;
            step_idx_d = '0;
            pat_idx_d  = '0;
            loop_cnt_d = '0;
            div_cnt_d  = '0;
        end else if (start) begin
            do_enter = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (div_cnt_q != lim_q) begin
                div_cnt_d = div_cnt_q + LENW'(1);
            end else if (step_idx_q != LAST_STEP) begin
                step_idx_d  = step_idx_q + SW'(1);
                div_cnt_d   = '0;
                lim_d       = len_lim;
                step_trig_d = 1'b1;
                gate_d      = act_pat_q[LAST_STEP - step_idx_d];
            end else if (({1'b0, loop_cnt_q} + 5'd1) < {1'b0, act_rep_q}) begin
                loop_cnt_d  = loop_cnt_q + 4'd1;
                step_idx_d  = '0;
                div_cnt_d   = '0;
                lim_d       = len_lim;
                step_trig_d = 1'b1;
                gate_d      = act_pat_q[DEPTH-1];
            end else if (nxt < NPAT_W && bank_rep_q[nxt[AW-1:0]] != 4'd0) begin
                do_enter   = 1'b1;
                enter_slot = nxt[AW-1:0];
            end else if (loop_mode) begin
                do_enter = 1'b1;
            end else begin
                do_end = 1'b1;
            end
        end

        // Entering a slot whose repeat count is 0 ends the chain instead.
        // The bank is read from the registered copy, so a write landing on
        // the same edge is not seen by this entry.
        if (do_enter && bank_rep_q[enter_slot] == 4'd0) begin
            do_enter = 1'b0;
            do_end   = 1'b1;
        end

        if (do_enter) begin
            state_d     = ST_RUN;
            act_pat_d   = bank_pat_q[enter_slot];
            act_rep_d   = bank_rep_q[enter_slot];
            pat_idx_d   = enter_slot;
            step_idx_d  = '0;
            loop_cnt_d  = '0;
            div_cnt_d   = '0;
            lim_d       = len_lim;
            step_trig_d = 1'b1;
            gate_d      = bank_pat_q[enter_slot][DEPTH-1];
        end

        if (do_end) begin
            state_d      = ST_IDLE;
            chain_done_d = 1'b1;
            step_idx_d   = '0;
            pat_idx_d    = '0;
            loop_cnt_d   = '0;
            div_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            lim_q        <= '0;
            step_idx_q   <= '0;
            pat_idx_q    <= '0;
            loop_cnt_q   <= '0;
            act_pat_q    <= '0;
            act_rep_q    <= '0;
            step_trig_q  <= 1'b0;
            gate_q       <= 1'b0;
            chain_done_q <= 1'b0;
            for (int i = 0; i < NPAT; i++) begin
                bank_pat_q[i] <= '0;
                bank_rep_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            lim_q        <= lim_d;
            step_idx_q   <= step_idx_d;
            pat_idx_q    <= pat_idx_d;
            loop_cnt_q   <= loop_cnt_d;
            act_pat_q    <= act_pat_d;
            act_rep_q    <= act_rep_d;
            step_trig_q  <= step_trig_d;
            gate_q       <= gate_d;
            chain_done_q <= chain_done_d;
            bank_pat_q   <= bank_pat_d;
            bank_rep_q   <= bank_rep_d;
        end
    end

    assign running    = (state_q == ST_RUN);
    assign step_trig  = step_trig_q;
    assign gate       = gate_q;
    assign step_idx   = step_idx_q;
    assign pat_idx    = pat_idx_q;
    assign chain_done = chain_done_q;

endmodule

// File: tb/tb_seq_chain_ctrl.sv
// tb/tb_seq_chain_ctrl.sv - self-checking bench for seq_chain_ctrl
module tb_seq_chain_ctrl;

    localparam int DEPTH = 4;
    localparam int NPAT  = 4;
    localparam int LENW  = 24;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            loop_mode = 1'b0;
    logic [LENW-1:0] len = '0;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_addr = '0;
    logic [3:0]      wr_pat = '0;
    logic [3:0]      wr_rep = '0;
    logic            running, step_trig, gate, chain_done;
    logic [1:0]      step_idx, pat_idx;

    seq_chain_ctrl #(.DEPTH(DEPTH), .NPAT(NPAT), .LENW(LENW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_mode(loop_mode),
        .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pat(wr_pat), .wr_rep(wr_rep),
        .running(running), .step_trig(step_trig), .gate(gate), .step_idx(step_idx),
        .pat_idx(pat_idx), .chain_done(chain_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench-side record of what was written to the bank
    logic [3:0] m_pat [NPAT];
    int         m_rep [NPAT];

    // Expected step sequence, flattened from the bank
    logic       e_gate [$];
    logic [1:0] e_pat  [$];
    logic [1:0] e_step [$];

    logic       cap_trig [256];
    logic       cap_gate [256];
    logic       cap_done [256];
    logic       cap_run  [256];
    logic [1:0] cap_pat  [256];
    logic [1:0] cap_step [256];

    function automatic void build_seq(input bit lm, input int max_ev);
        int slot;
        slot = 0;
        e_gate.delete(); e_pat.delete(); e_step.delete();
        if (m_rep[0] == 0) return;
        while (1) begin
            for (int r = 0; r < m_rep[slot]; r++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (e_gate.size() >= max_ev) return;
                    e_gate.push_back(m_pat[slot][DEPTH-1-s]);
                    e_pat.push_back(2'(slot));
                    e_step.push_back(2'(s));
                end
            end
            if (slot + 1 < NPAT && m_rep[slot+1] != 0) slot++;
            else if (lm) slot = 0;
            else return;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NPAT; i++) begin
            m_pat[i] = '0;
            m_rep[i] = 0;
        end
    endtask

    task automatic write_slot(input int a, input logic [3:0] p, input int r);
        wr_en = 1'b1; wr_addr = 2'(a); wr_pat = p; wr_rep = 4'(r);
        @(negedge clk);
        wr_en = 1'b0;
        m_pat[a] = p;
        m_rep[a] = r;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample index 1 is the first cycle after the start edge
    task automatic capture(input int n);
        for (int c = 1; c <= n; c++) begin
            cap_trig[c] = step_trig; cap_gate[c] = gate; cap_done[c] = chain_done;
            cap_run[c] = running; cap_pat[c] = pat_idx; cap_step[c] = step_idx;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({running, step_trig, gate, chain_done, step_idx, pat_idx} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp 00000000",
                     {running, step_trig, gate, chain_done, step_idx, pat_idx});
        end
        write_slot(0, 4'b1010, 1);
        len = 24'd2;
        pulse_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({running, step_trig, gate, chain_done, step_idx, pat_idx} !== 8'h00) begin
            n_fail++;
            $display("FAIL midstep_reset_outputs got %b exp 00000000",
                     {running, step_trig, gate, chain_done, step_idx, pat_idx});
        end
        do_reset();
        pulse_start();
        n_tests++;
        if ({chain_done, running} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_clears_bank done/running got %b exp 10", {chain_done, running});
        end
    endtask

    task automatic test_single_pass();
        int L, nev, ncap, idx;
        bit et, ed, er;
        for (int sc = 0; sc < 8; sc++) begin
            do_reset();
            loop_mode = 1'b0;
            case (sc)
                0: begin
                    write_slot(0, 4'b1010, 2);
                    len = 24'd3;
                end
                1: begin
                    write_slot(0, 4'hF, 1); write_slot(1, 4'h0, 1);
                    write_slot(2, 4'hF, 1); write_slot(3, 4'h0, 1);
                    len = 24'd2;
                end
                default: begin
                    for (int i = 0; i < NPAT; i++)
                        write_slot(i, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
                    len = LENW'($urandom_range(0, 3));
                end
            endcase
            L = (len == '0) ? 1 : int'(len);
            build_seq(1'b0, 1000);
            nev  = e_gate.size();
            ncap = nev * L + 4;
            pulse_start();
            capture(ncap);
            for (int c = 1; c <= ncap; c++) begin
                idx = (c - 1) / L;
                et  = ((c - 1) % L == 0) && (idx < nev);
                ed  = (c == nev * L + 1);
                er  = (c <= nev * L);
                n_tests++;
                if (cap_trig[c] !== et) begin
                    n_fail++;
                    $display("FAIL sp%0d_trig c=%0d got %b exp %b", sc, c, cap_trig[c], et);
                end
                n_tests++;
                if (cap_done[c] !== ed) begin
                    n_fail++;
                    $display("FAIL sp%0d_done c=%0d got %b exp %b", sc, c, cap_done[c], ed);
                end
                n_tests++;
                if (cap_run[c] !== er) begin
                    n_fail++;
                    $display("FAIL sp%0d_running c=%0d got %b exp %b", sc, c, cap_run[c], er);
                end
                n_tests++;
                if (et) begin
                    if ({cap_gate[c], cap_pat[c], cap_step[c]} !== {e_gate[idx], e_pat[idx], e_step[idx]}) begin
                        n_fail++;
                        $display("FAIL sp%0d_step c=%0d gate/pat/step got %b/%0d/%0d exp %b/%0d/%0d", sc, c,
                                 cap_gate[c], cap_pat[c], cap_step[c], e_gate[idx], e_pat[idx], e_step[idx]);
                    end
                end else if (cap_gate[c] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sp%0d_gate_idle c=%0d got %b exp 0", sc, c, cap_gate[c]);
                end
            end
        end
    endtask

    task automatic test_loop_mode();
        do_reset();
        write_slot(0, 4'b1100, 1);
        write_slot(1, 4'b0011, 1);
        loop_mode = 1'b1;
        len = 24'd1;
        build_seq(1'b1, 24);
        pulse_start();
        capture(24);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            n_tests++;
            if ({cap_trig[c], cap_done[c], cap_run[c]} !== 3'b101) begin
                n_fail++;
                $display("FAIL loop_ctrl c=%0d trig/done/run got %b exp 101", c,
                         {cap_trig[c], cap_done[c], cap_run[c]});
            end
            n_tests++;
            if ({cap_gate[c], cap_pat[c], cap_step[c]} !== {e_gate[c-1], e_pat[c-1], e_step[c-1]}) begin
                n_fail++;
                $display("FAIL loop_step c=%0d gate/pat/step got %b/%0d/%0d exp %b/%0d/%0d", c,
                         cap_gate[c], cap_pat[c], cap_step[c], e_gate[c-1], e_pat[c-1], e_step[c-1]);
            end
        end
        n_tests++;
        if ({running, step_trig, chain_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL loop_stop got %b exp 000", {running, step_trig, chain_done});
        end
        loop_mode = 1'b0;
    endtask

    task automatic test_len();
        bit et, ed;
        do_reset();
        write_slot(0, 4'b1010, 1);
        loop_mode = 1'b0;
        len = 24'd0;
        build_seq(1'b0, 1000);
        pulse_start();
        capture(6);
        for (int c = 1; c <= 6; c++) begin
            et = (c <= 4);
            ed = (c == 5);
            n_tests++;
            if ({cap_trig[c], cap_done[c]} !== {et, ed}) begin
                n_fail++;
                $display("FAIL len0_trig_done c=%0d got %b exp %b", c, {cap_trig[c], cap_done[c]}, {et, ed});
            end
            if (et) begin
                n_tests++;
                if (cap_gate[c] !== e_gate[c-1]) begin
                    n_fail++;
                    $display("FAIL len0_gate c=%0d got %b exp %b", c, cap_gate[c], e_gate[c-1]);
                end
            end
        end
        // First step keeps the length taken at start; later steps use the new one
        len = 24'd3;
        pulse_start();
        for (int c = 1; c <= 22; c++) begin
            et = (c == 1) || (c >= 4 && c <= 14 && (c - 4) % 5 == 0);
            ed = (c == 19);
            n_tests++;
            if ({step_trig, chain_done} !== {et, ed}) begin
                n_fail++;
                $display("FAIL lenchg_trig_done c=%0d got %b exp %b", c, {step_trig, chain_done}, {et, ed});
            end
            if (c == 2) len = 24'd5;
            @(negedge clk);
        end
    endtask

    task automatic test_stop_start();
        do_reset();
        write_slot(0, 4'b1010, 1);
        write_slot(1, 4'b0110, 1);
        loop_mode = 1'b0;
        len = 24'd3;
        pulse_start();
        n_tests++;
        if (step_trig !== 1'b1) begin
            n_fail++;
            $display("FAIL ss_first_trig got %b exp 1", step_trig);
        end
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_tests++;
        if ({running, step_trig, gate, step_idx, pat_idx} !== 7'b0) begin
            n_fail++;
            $display("FAIL ss_stop_state got %b exp 0000000", {running, step_trig, gate, step_idx, pat_idx});
        end
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if ({step_trig, chain_done, running} !== 3'b000) begin
                n_fail++;
                $display("FAIL ss_after_stop c=%0d got %b exp 000", c, {step_trig, chain_done, running});
            end
            @(negedge clk);
        end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        n_tests++;
        if ({running, step_trig, chain_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL ss_both_idle got %b exp 000", {running, step_trig, chain_done});
        end
        len = 24'd1;
        pulse_start();
        repeat (5) @(negedge clk);
        n_tests++;
        if ({pat_idx, step_idx} !== 4'b0101) begin
            n_fail++;
            $display("FAIL ss_midchain pat/step got %0d/%0d exp 1/1", pat_idx, step_idx);
        end
        pulse_start();
        n_tests++;
        if ({running, step_trig, gate, step_idx, pat_idx} !== 7'b1110000) begin
            n_fail++;
            $display("FAIL ss_restart got %b exp 1110000", {running, step_trig, gate, step_idx, pat_idx});
        end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        n_tests++;
        if ({running, step_trig, chain_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL ss_both_run got %b exp 000", {running, step_trig, chain_done});
        end
    endtask

    task automatic test_bank_write();
        int p, o, s;
        logic [3:0] pp;
        logic [3:0] s1pat;
        logic eg;
        logic [1:0] ep;
        do_reset();
        write_slot(0, 4'b1111, 2);
        write_slot(1, 4'b0110, 1);
        loop_mode = 1'b1;
        len = 24'd1;
        pulse_start();
        fork
            capture(48);
            begin
                repeat (2) @(negedge clk);
                wr_en = 1'b1; wr_addr = 2'd0; wr_pat = 4'b0000; wr_rep = 4'd2;
                @(negedge clk);
                wr_en = 1'b0;
                repeat (20) @(negedge clk);
                // Lands on the same edge that re-enters slot 0 for the third pass
                wr_en = 1'b1; wr_addr = 2'd0; wr_pat = 4'b1001; wr_rep = 4'd2;
                @(negedge clk);
                wr_en = 1'b0;
            end
        join
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        s1pat = 4'b0110;
        for (int c = 1; c <= 48; c++) begin
            p  = (c - 1) / 12;
            o  = (c - 1) % 12;
            pp = (p == 0) ? 4'hF : (p == 3) ? 4'h9 : 4'h0;
            if (o < 8) begin
                s = o % 4; ep = 2'd0; eg = pp[3-s];
            end else begin
                s = o - 8; ep = 2'd1; eg = s1pat[3-s];
            end
            n_tests++;
            if ({cap_trig[c], cap_done[c], cap_gate[c], cap_pat[c], cap_step[c]} !== {1'b1, 1'b0, eg, ep, 2'(s)}) begin
                n_fail++;
                $display("FAIL bankwr c=%0d trig/done/gate/pat/step got %b%b%b/%0d/%0d exp 10%b/%0d/%0d", c,
                         cap_trig[c], cap_done[c], cap_gate[c], cap_pat[c], cap_step[c], eg, ep, s);
            end
        end
        loop_mode = 1'b0;
    endtask

    task automatic test_rep_zero();
        do_reset();
        write_slot(0, 4'b1111, 0);
        pulse_start();
        n_tests++;
        if ({chain_done, running, step_trig} !== 3'b100) begin
            n_fail++;
            $display("FAIL rep0_start got %b exp 100", {chain_done, running, step_trig});
        end
        @(negedge clk);
        n_tests++;
        if ({chain_done, running, step_trig} !== 3'b000) begin
            n_fail++;
            $display("FAIL rep0_after got %b exp 000", {chain_done, running, step_trig});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pass();
        test_loop_mode();
        test_len();
        test_stop_start();
        test_bank_write();
        test_rep_zero();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
